// File: rtl/pcie_tlp_pkg.sv
// Shared PCIe TLP definitions: TX word width, watchdog default, header field encodings.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pcie_tlp_pkg;

    localparam int TX_W        = 16;
    localparam int TMO_DEFAULT = 1024;

    // TLP header fmt field (DW count / data presence)
    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
    localparam logic [2:0] FMT_4DW_DATA   = 3'b011;

    // TLP header type field
    localparam logic [4:0] TYPE_MEM = 5'b00000;
    localparam logic [4:0] TYPE_CPL = 5'b01010;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_XFER = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pcie_rr_picker.sv
// Rotate-priority encoder: first set req bit at or after ptr, wrapping modulo NREQ.
// Latency: combinational.
// Backpressure: none; valid low when no request is pending.
module pcie_rr_picker #(
    parameter int NREQ = 2,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            valid
);

    logic [ID_W-1:0] cand;

    // Scan from the farthest slot back towards ptr so the nearest requester is written last and wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                winner = cand;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Round-robin share of the 16-bit PCIe TX port among NREQ sources, locked per TLP, with a watchdog.
// Latency: owner stream forwarded through one register stage (1 cycle).
// Backpressure: tx_req held until tx_rdy; sources hold req until their one-cycle gnt pulse.
module pcie_tx_arbiter
    import pcie_tlp_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ID_W    = $clog2(NREQ),
    parameter int TMO_CYC = TMO_DEFAULT
) (
    input  logic                 pcie_clk,
    input  logic                 sys_rst_n,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      gnt,
    input  logic [NREQ-1:0]      src_st,
    input  logic [NREQ-1:0]      src_end,
    input  logic [NREQ*TX_W-1:0] src_data,
    output logic                 tx_req,
    input  logic                 tx_rdy,
    output logic                 tx_st,
    output logic                 tx_end,
    output logic [TX_W-1:0]      tx_data,
    output logic                 busy,
    output logic [ID_W-1:0]      owner,
    output logic                 err_timeout,
    output logic                 err_proto,
    input  logic                 clr_err
);

    localparam int               CNT_W    = $clog2(TMO_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NREQ - 1);

    arb_state_t        state, state_nxt;
    logic [ID_W-1:0]   owner_nxt, rr_ptr, rr_nxt, owner_inc, pick_id;
    logic              pick_vld;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              in_pkt, in_pkt_nxt;
    logic              tx_req_nxt, st_nxt, end_nxt;
    logic [NREQ-1:0]   gnt_nxt, own_mask, strobes;
    logic [TX_W-1:0]   data_nxt;
    logic              tmo_set, proto_set;
    logic [TX_W-1:0]   src_word [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign src_word[g] = src_data[g*TX_W +: TX_W];
    end

    assign owner_inc = (owner == ID_LAST) ? '0 : owner + ID_W'(1);
    assign own_mask  = NREQ'(1) << owner;
    assign strobes   = src_st | src_end;
    // busy covers the tx_end beat, so it drops the cycle after the TLP closes.
    assign busy      = (state != ARB_IDLE) | tx_end;

    pcie_rr_picker #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_picker (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (pick_id),
        .valid  (pick_vld)
    );

    // Next-state, forwarding mux, watchdog and error detection.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_nxt     = rr_ptr;
        cnt_nxt    = cnt;
        in_pkt_nxt = in_pkt;
        tx_req_nxt = 1'b0;
        gnt_nxt    = '0;
        st_nxt     = 1'b0;
        end_nxt    = 1'b0;
        data_nxt   = '0;
        tmo_set    = 1'b0;
        proto_set  = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                in_pkt_nxt = 1'b0;
                proto_set  = |strobes;
                if (pick_vld) begin
                    owner_nxt  = pick_id;
                    tx_req_nxt = 1'b1;
                    state_nxt  = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                proto_set  = |strobes;
                tx_req_nxt = ~tx_rdy;
                if (tx_rdy) begin
                    gnt_nxt   = own_mask;
                    cnt_nxt   = '0;
                    state_nxt = ARB_XFER;
                end
            end
            ARB_XFER: begin
                // A second start inside an open packet is dropped and flagged.
                proto_set = (|(strobes & ~own_mask)) | (src_st[owner] & in_pkt);
                cnt_nxt   = cnt + CNT_W'(1);
                st_nxt    = src_st[owner] & ~in_pkt;
                end_nxt   = src_end[owner];
                data_nxt  = src_word[owner];
                if (src_end[owner]) begin
                    in_pkt_nxt = 1'b0;
                    rr_nxt     = owner_inc;
                    state_nxt  = ARB_IDLE;
                end else if (cnt == CNT_LAST) begin
                    st_nxt     = 1'b0;
                    end_nxt    = 1'b1;
                    data_nxt   = '0;
                    tmo_set    = 1'b1;
                    in_pkt_nxt = 1'b0;
                    rr_nxt     = owner_inc;
                    state_nxt  = ARB_IDLE;
                end else if (src_st[owner]) begin
                    in_pkt_nxt = 1'b1;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // State and output registers; sticky flags give set priority over clr_err.
    always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ARB_IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            cnt         <= '0;
            in_pkt      <= 1'b0;
            tx_req      <= 1'b0;
            gnt         <= '0;
            tx_st       <= 1'b0;
            tx_end      <= 1'b0;
            tx_data     <= '0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            rr_ptr      <= rr_nxt;
            cnt         <= cnt_nxt;
            in_pkt      <= in_pkt_nxt;
            tx_req      <= tx_req_nxt;
            gnt         <= gnt_nxt;
            tx_st       <= st_nxt;
            tx_end      <= end_nxt;
            tx_data     <= data_nxt;
            err_timeout <= tmo_set | (err_timeout & ~clr_err);
            err_proto   <= proto_set | (err_proto & ~clr_err);
        end
    end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: directed scenarios plus random rounds against a transaction-level model.
// Latency: checks one-cycle forwarding and TMO_CYC-cycle watchdog.
// Backpressure: drives tx_rdy with random delays after tx_req.
module tb_pcie_tx_arbiter;

    localparam int NREQ    = 2;
    localparam int ID_W    = 1;
    localparam int TMO_CYC = 16;

    logic                 pcie_clk = 1'b0;
    logic                 sys_rst_n;
    logic [NREQ-1:0]      req, gnt, src_st, src_end;
    logic [NREQ*16-1:0]   src_data;
    logic                 tx_req, tx_rdy, tx_st, tx_end;
    logic [15:0]          tx_data;
    logic                 busy;
    logic [ID_W-1:0]      owner;
    logic                 err_timeout, err_proto, clr_err;

    int              n_checks = 0;
    int              n_errs   = 0;
    logic [NREQ-1:0] pending  = '0;
    logic [NREQ-1:0] req_last = '0;
    logic [NREQ-1:0] arb_req  = '0;
    bit              arb_flag = 1'b0;
    logic            tx_req_q = 1'b0;
    int              m_ptr    = 0;
    bit              m_tmo    = 1'b0;
    bit              m_proto  = 1'b0;

    pcie_tx_arbiter #(
        .NREQ    (NREQ),
        .ID_W    (ID_W),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .pcie_clk    (pcie_clk),
        .sys_rst_n   (sys_rst_n),
        .req         (req),
        .gnt         (gnt),
        .src_st      (src_st),
        .src_end     (src_end),
        .src_data    (src_data),
        .tx_req      (tx_req),
        .tx_rdy      (tx_rdy),
        .tx_st       (tx_st),
        .tx_end      (tx_end),
        .tx_data     (tx_data),
        .busy        (busy),
        .owner       (owner),
        .err_timeout (err_timeout),
        .err_proto   (err_proto),
        .clr_err     (clr_err)
    );

    initial forever #5 pcie_clk = ~pcie_clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", n_errs);
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Round-robin rule: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // One clock; remember the request vector that was present when tx_req rose.
    task automatic tick();
        req_last = req;
        @(posedge pcie_clk);
        #1;
        if (tx_req && !tx_req_q) begin
            arb_req  = req_last;
            arb_flag = 1'b1;
        end
        tx_req_q = tx_req;
    endtask

    task automatic wait_arb();
        for (int n = 0; n < 20 && !arb_flag; n++) tick();
        chk("arb_seen", arb_flag, 1);
    endtask

    // One arbitration plus one TLP from the winner; words sit at cycles gap+1..gap+len after gnt.
    task automatic round(input logic [NREQ-1:0] add, input int rdy_dly, input int gap, input int len,
                         input bit no_end, input bit fixed, input logic [15:0] w0, input int proto_at);
        int         w, j, k;
        bit         done, d_st, d_end;
        logic [15:0] d_data;
        pending = pending | add;
        req     = pending;
        wait_arb();
        if (!arb_flag) return;
        arb_flag = 1'b0;
        w = pick(arb_req, m_ptr);
        chk("arb_req_nonzero", (w >= 0), 1);
        if (w < 0) w = 0;
        chk("owner", owner, w);
        chk("busy_wait", busy, 1);
        repeat (rdy_dly) tick();
        chk("tx_req_hold", {gnt, tx_req}, 3'b001);
        tx_rdy = 1'b1;
        tick();
        tx_rdy = 1'b0;
        chk("gnt", {gnt, tx_req}, {NREQ'(1) << w, 1'b0});
        chk("tx_idle_at_gnt", {tx_st, tx_end, tx_data}, 0);
        pending[w] = 1'b0;
        req = pending;
        j = 0;
        done = 1'b0;
        while (!done) begin
            k      = j - 1 - gap;
            d_st   = 1'b0;
            d_end  = 1'b0;
            d_data = 16'($urandom);
            if (j >= 1 && k >= 0 && k < len) begin
                d_st   = (k == 0);
                d_end  = (k == len - 1) && !no_end;
                d_data = fixed ? ((k == 0) ? w0 : 16'(k)) : 16'($urandom);
            end
            src_st  = '0;
            src_end = '0;
            src_st[w]  = d_st;
            src_end[w] = d_end;
            for (int i = 0; i < NREQ; i++)
                src_data[16*i +: 16] = (i == w) ? d_data : 16'($urandom);
            if (j == proto_at) begin
                src_st[(w + 1) % NREQ] = 1'b1;
                m_proto = 1'b1;
            end
            tick();
            j++;
            if (j == 1) chk("gnt_pulse", gnt, 0);
            if (d_end) begin
                chk("fwd_last", {tx_st, tx_end, tx_data}, {d_st, 1'b1, d_data});
                chk("busy_on_end", busy, 1);
                done = 1'b1;
            end else if (j == TMO_CYC) begin
                chk("wdog_end", {tx_st, tx_end, tx_data}, {1'b0, 1'b1, 16'h0});
                m_tmo = 1'b1;
                done  = 1'b1;
            end else begin
                chk("fwd", {tx_st, tx_end, tx_data}, {d_st, 1'b0, d_data});
            end
        end
        src_st   = '0;
        src_end  = '0;
        src_data = '0;
        m_ptr    = (w + 1) % NREQ;
        tick();
        chk("tx_after_end", {tx_st, tx_end, tx_data}, 0);
        if (req_last == '0) chk("busy_after", busy, 0);
        chk("err_timeout", err_timeout, m_tmo);
        chk("err_proto", err_proto, m_proto);
    endtask

    initial begin
        logic [NREQ-1:0] a;
        sys_rst_n = 1'b0;
        req       = '0;
        src_st    = '0;
        src_end   = '0;
        src_data  = '0;
        tx_rdy    = 1'b0;
        clr_err   = 1'b0;
        tick();
        tick();
        chk("rst_outputs", {gnt, tx_req, tx_st, tx_end, tx_data, busy, owner, err_timeout, err_proto}, 0);
        sys_rst_n = 1'b1;
        tick();
        chk("idle_no_req", {tx_req, busy}, 0);

        // Contention: both request, back-to-back 4-word TLPs, order 0,1,0,1.
        round(2'b11, 0, 0, 4, 0, 0, 16'h0, -1);
        round(2'b01, 0, 0, 4, 0, 0, 16'h0, -1);
        round(2'b10, 0, 0, 4, 0, 0, 16'h0, -1);
        round(2'b00, 0, 0, 4, 0, 0, 16'h0, -1);

        // Single source, tx_rdy after 3 cycles, 6-word TLP starting 0x4A00.
        round(2'b01, 3, 0, 6, 0, 1, 16'h4A00, -1);
        // Single-word TLP.
        round(2'b01, 1, 1, 1, 0, 1, 16'h1234, -1);
        // End exactly on the watchdog limit: normal completion.
        round(2'b10, 0, 9, 6, 0, 0, 16'h0, -1);
        // Owner 1 never ends: forced end, then source 0 wins.
        round(2'b10, 2, 0, 4, 1, 0, 16'h0, -1);
        round(2'b11, 0, 0, 3, 0, 0, 16'h0, -1);
        round(2'b00, 0, 0, 3, 0, 0, 16'h0, -1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        m_tmo = 1'b0;
        chk("clr_timeout", err_timeout, m_tmo);

        // Non-owner start strobe while source 0 owns.
        round(2'b01, 0, 3, 4, 0, 0, 16'h0, 2);
        // Strobe outside XFER together with clr_err: set wins.
        clr_err    = 1'b1;
        src_end[1] = 1'b1;
        tick();
        clr_err = 1'b0;
        src_end = '0;
        m_proto = 1'b1;
        chk("proto_set_wins", err_proto, m_proto);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        m_proto = 1'b0;
        chk("clr_proto", err_proto, m_proto);
        src_st[0] = 1'b1;
        tick();
        src_st = '0;
        m_proto = 1'b1;
        chk("proto_idle_strobe", err_proto, m_proto);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        m_proto = 1'b0;

        // Random rounds.
        for (int n = 0; n < 40; n++) begin
            a = NREQ'($urandom_range(0, 3));
            if ((pending | a) == '0) a = NREQ'(1) << $urandom_range(0, NREQ - 1);
            round(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 6), 0, 0, 16'h0, -1);
        end
        for (int n = 0; n < 4 && pending != '0; n++)
            round(2'b00, 0, 0, 2, 0, 0, 16'h0, -1);

        // Reset during word 3 of a source-1 packet, with the pointer parked at 1.
        round(2'b01, 0, 0, 3, 0, 0, 16'h0, -1);
        req = 2'b10;
        wait_arb();
        arb_flag = 1'b0;
        chk("rst_owner", owner, 1);
        tx_rdy = 1'b1;
        tick();
        tx_rdy = 1'b0;
        req = '0;
        chk("rst_gnt", gnt, 2'b10);
        tick();
        for (int k = 0; k < 3; k++) begin
            src_st   = {(k == 0), 1'b0};
            src_data = {16'hA001 + 16'(k), 16'h0};
            if (k < 2) tick();
        end
        chk("pre_rst_data", tx_data, 16'hA002);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rst_async", {gnt, tx_req, tx_st, tx_end, tx_data, busy}, 0);
        src_st   = '0;
        src_data = '0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        m_ptr    = 0;
        m_tmo    = 1'b0;
        m_proto  = 1'b0;
        arb_flag = 1'b0;
        chk("rst_flags", {err_timeout, err_proto, owner}, 0);
        round(2'b11, 0, 0, 2, 0, 0, 16'h0, -1);
        round(2'b00, 0, 0, 2, 0, 0, 16'h0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
